// File: rtl/stage_4_pkg.sv
// ============================================================================
// Module      : stage_4_pkg
// Description : Shared constants, FSM state type and helper functions for the
//               RV32I memory-access stage (stage_4) and its load formatter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package stage_4_pkg;

   // Opcodes the stage needs to recognise
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   // Load width/sign codes
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // Store width codes
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   // Bus-access FSM states
   typedef enum logic [0:0] {
      ST_IDLE     = 1'b0,
      ST_WAIT_ACK = 1'b1
   } state_t;

   function automatic logic [31:0] sign_extend_8(input logic [7:0] v);
      return {{24{v[7]}}, v};
   endfunction

   function automatic logic [31:0] sign_extend_16(input logic [15:0] v);
      return {{16{v[15]}}, v};
   endfunction

   // Byte enables for a store; the low address bits only steer byte/half lanes
   function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] a);
      case (f3[1:0])
         2'b00:   return 4'b0001 << a;
         2'b01:   return 4'b0011 << {a[1], 1'b0};
         default: return 4'hF;
      endcase
   endfunction

   // Store data replicated into every lane so the enables alone pick the target
   function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
      case (f3[1:0])
         2'b00:   return {4{d[7:0]}};
         2'b01:   return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

   // Halfword needs a[0]=0, word needs a[1:0]=0; bytes are never misaligned
   function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
      case (f3[1:0])
         2'b01:   return a[0];
         2'b10:   return |a;
         default: return 1'b0;
      endcase
   endfunction

   // Register write only for real destinations of result-producing opcodes
   function automatic logic wb_enable(input logic [4:0] rd, input logic [6:0] opcode);
      return (rd != 5'd0) && (opcode != OP_STORE) && (opcode != OP_BRANCH);
   endfunction

endpackage

`default_nettype wire

// File: rtl/stage_4_load_align.sv
// ============================================================================
// Module      : stage_4_load_align
// Description : Combinational load formatter: selects byte/half by address
//               and sign- or zero-extends according to the load width code.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stage_4_load_align
   import stage_4_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  addr,
   input  logic [2:0]  func_3,
   output logic [31:0] data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Lane selection and extension of the returned word
   always_comb begin
      w_byte = rdata[7:0];
      case (addr)
         2'd0:    w_byte = rdata[7:0];
         2'd1:    w_byte = rdata[15:8];
         2'd2:    w_byte = rdata[23:16];
         default: w_byte = rdata[31:24];
      endcase
      w_half = addr[1] ? rdata[31:16] : rdata[15:0];
      case (func_3)
         F3_LB:   data = sign_extend_8(w_byte);
         F3_LH:   data = sign_extend_16(w_half);
         F3_LBU:  data = {24'd0, w_byte};
         F3_LHU:  data = {16'd0, w_half};
         default: data = rdata;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/stage_4.sv
// ============================================================================
// Module      : stage_4
// Description : RV32I memory-access stage. ALU results pass through with one
//               cycle of latency; loads/stores run on a req/ack bus and stall
//               upstream until acknowledged or timed out.
//               Optional macro MISALIGN_TRAP_EN adds o_misaligned and traps
//               misaligned half/word accesses instead of forcing alignment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module stage_4
   import stage_4_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        i_valid,
   input  logic [31:0] i_alu_out,
   input  logic [31:0] i_rs_2,
   input  logic [4:0]  i_rd_num,
   input  logic [6:0]  i_opcode,
   input  logic [2:0]  i_func_3,
   input  logic        i_op_type,
   output logic        o_stall,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_be,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic        o_valid,
   output logic [4:0]  o_rd_num,
   output logic [31:0] o_wb_data,
   output logic        o_wb_en,
   output logic        o_bus_err
`ifdef MISALIGN_TRAP_EN
   ,
   output logic        o_misaligned
`endif
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] c_TMO_LAST =
      CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

   state_t             r_state;
   state_t             w_next;
   logic [CNT_W-1:0]   r_cnt;
   logic [31:0]        r_addr;
   logic [4:0]         r_rd;
   logic [6:0]         r_opcode;
   logic [2:0]         r_func3;
   logic [31:0]        w_load_val;
   logic               w_tmo_hit;
   logic               w_mis_trap;

   assign w_tmo_hit = (TIMEOUT_CYCLES != 0) && (r_cnt == c_TMO_LAST);

`ifdef MISALIGN_TRAP_EN
   assign w_mis_trap = is_misaligned(i_func_3, i_alu_out[1:0]);
`else
   assign w_mis_trap = 1'b0;
`endif

   stage_4_load_align u_load_align (
      .rdata  (mem_rdata),
      .addr   (r_addr[1:0]),
      .func_3 (r_func3),
      .data   (w_load_val)
   );

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   // Next-state decode and upstream stall
   always_comb begin
      w_next  = r_state;
      o_stall = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (i_valid && i_op_type && !w_mis_trap) w_next = ST_WAIT_ACK;
         end
         ST_WAIT_ACK: begin
            o_stall = 1'b1;
            if (mem_ack || w_tmo_hit) w_next = ST_IDLE;
         end
         default: w_next = ST_IDLE;
      endcase
   end

   // Bus request, access latch, timeout counter and writeback bundle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt     <= '0;
         r_addr    <= '0;
         r_rd      <= '0;
         r_opcode  <= '0;
         r_func3   <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_be    <= '0;
         o_valid   <= 1'b0;
         o_rd_num  <= '0;
         o_wb_data <= '0;
         o_wb_en   <= 1'b0;
         o_bus_err <= 1'b0;
`ifdef MISALIGN_TRAP_EN
         o_misaligned <= 1'b0;
`endif
      end else begin
         o_valid   <= 1'b0;
         o_bus_err <= 1'b0;
`ifdef MISALIGN_TRAP_EN
         o_misaligned <= 1'b0;
`endif
         case (r_state)
            ST_IDLE: begin
               r_cnt <= '0;
               if (i_valid && !i_op_type) begin
                  o_valid   <= 1'b1;
                  o_rd_num  <= i_rd_num;
                  o_wb_data <= i_alu_out;
                  o_wb_en   <= wb_enable(i_rd_num, i_opcode);
               end else if (i_valid && w_mis_trap) begin
                  o_valid   <= 1'b1;
                  o_rd_num  <= i_rd_num;
                  o_wb_data <= i_alu_out;
                  o_wb_en   <= 1'b0;
`ifdef MISALIGN_TRAP_EN
                  o_misaligned <= 1'b1;
`endif
               end else if (i_valid) begin
                  r_addr    <= i_alu_out;
                  r_rd      <= i_rd_num;
                  r_opcode  <= i_opcode;
                  r_func3   <= i_func_3;
                  mem_req   <= 1'b1;
                  mem_we    <= (i_opcode == OP_STORE);
                  mem_addr  <= {i_alu_out[31:2], 2'b00};
                  mem_be    <= (i_opcode == OP_STORE) ? store_be(i_func_3, i_alu_out[1:0]) : 4'hF;
                  mem_wdata <= store_wdata(i_func_3, i_rs_2);
               end
            end
            ST_WAIT_ACK: begin
               r_cnt <= r_cnt + 1'b1;
               if (mem_ack) begin
                  // Stores report their effective address; nothing is written back
                  mem_req   <= 1'b0;
                  o_valid   <= 1'b1;
                  o_rd_num  <= r_rd;
                  o_wb_en   <= wb_enable(r_rd, r_opcode);
                  o_wb_data <= (r_opcode == OP_STORE) ? r_addr : w_load_val;
               end else if (w_tmo_hit) begin
                  mem_req   <= 1'b0;
                  o_valid   <= 1'b1;
                  o_bus_err <= 1'b1;
                  o_rd_num  <= r_rd;
                  o_wb_en   <= 1'b0;
                  o_wb_data <= '0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_stage_4.sv
// ============================================================================
// Module      : tb_stage_4
// Description : Self-checking bench for stage_4 using directed vectors and a
//               behavioural expectation model compared every cycle.
//               Honours MISALIGN_TRAP_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stage_4;

   localparam int TMO = 16;
   localparam logic [6:0] OPC_ALU = 7'b0010011, OPC_LD = 7'b0000011,
                          OPC_ST = 7'b0100011, OPC_BR = 7'b1100011;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_valid, i_op_type;
   logic [31:0] i_alu_out, i_rs_2, mem_rdata;
   logic [4:0]  i_rd_num;
   logic [6:0]  i_opcode;
   logic [2:0]  i_func_3;
   logic        mem_ack;
   logic        o_stall, mem_req, mem_we, o_valid, o_wb_en, o_bus_err;
   logic [31:0] mem_addr, mem_wdata, o_wb_data;
   logic [3:0]  mem_be;
   logic [4:0]  o_rd_num;
`ifdef MISALIGN_TRAP_EN
   logic        o_misaligned;
   logic        exp_mis = 1'b0;
`endif

   // expectation state for the current cycle
   logic        exp_valid = 0, exp_stall = 0, exp_req = 0, exp_we = 0, exp_wen = 0, exp_err = 0;
   logic [31:0] exp_addr = 0, exp_wdata = 0, exp_data = 0;
   logic [3:0]  exp_be = 0;
   logic [4:0]  exp_rd = 0;
   logic [31:0] obs_addr, obs_wdata;
   logic [3:0]  obs_be;
   int          n_pass = 0, n_total = 0;

   always #5 clk = ~clk;

   stage_4 #(.TIMEOUT_CYCLES(TMO)) dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_alu_out(i_alu_out), .i_rs_2(i_rs_2),
      .i_rd_num(i_rd_num), .i_opcode(i_opcode), .i_func_3(i_func_3), .i_op_type(i_op_type),
      .o_stall(o_stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .o_valid(o_valid), .o_rd_num(o_rd_num), .o_wb_data(o_wb_data), .o_wb_en(o_wb_en),
      .o_bus_err(o_bus_err)
`ifdef MISALIGN_TRAP_EN
      , .o_misaligned(o_misaligned)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // ---- behavioural model: arithmetic view of RV32I memory semantics ----
   function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] a, input logic [2:0] f3);
      logic [31:0] b, h;
      int lane;
      lane = a % 4;
      b = (rd >> (8 * lane)) & 32'hFF;
      h = (rd >> (16 * (lane / 2))) & 32'hFFFF;
      case (f3)
         3'b000:  return (b >= 32'h80) ? b - 32'h100 : b;
         3'b001:  return (h >= 32'h8000) ? h - 32'h10000 : h;
         3'b100:  return b;
         3'b101:  return h;
         default: return rd;
      endcase
   endfunction

   function automatic logic [3:0] m_be(input logic [31:0] a, input logic [2:0] f3);
      if (f3 == 3'b000) return 4'(1 << (a % 4));
      if (f3 == 3'b001) return 4'(3 << (a & 2));
      return 4'hF;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [31:0] d, input logic [2:0] f3);
      if (f3 == 3'b000) return (d & 32'hFF) * 32'h0101_0101;
      if (f3 == 3'b001) return (d & 32'hFFFF) * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic m_misaligned(input logic [31:0] a, input logic [2:0] f3);
      if (f3[1:0] == 2'b01) return (a % 2) != 0;
      if (f3[1:0] == 2'b10) return (a % 4) != 0;
      return 1'b0;
   endfunction

   // per-cycle comparison of DUT outputs against the model state
   always @(negedge clk) begin
      chk("o_valid", o_valid, exp_valid);
      chk("o_stall", o_stall, exp_stall);
      chk("mem_req", mem_req, exp_req);
      chk("o_rd_num", o_rd_num, exp_rd);
      chk("o_wb_data", o_wb_data, exp_data);
      if (exp_valid) begin
         chk("o_wb_en", o_wb_en, exp_wen);
         chk("o_bus_err", o_bus_err, exp_err);
      end else begin
         chk("o_bus_err_idle", o_bus_err, 0);
      end
      if (exp_req) begin
         chk("mem_addr", mem_addr, exp_addr);
         chk("mem_we", mem_we, exp_we);
         chk("mem_be", mem_be, exp_be);
         if (exp_we) chk("mem_wdata", mem_wdata, exp_wdata);
      end
`ifdef MISALIGN_TRAP_EN
      chk("o_misaligned", o_misaligned, exp_mis);
`endif
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      i_valid = 0;
      for (int k = 0; k < n; k++) begin
         tick();
         exp_valid = 0; exp_req = 0; exp_stall = 0;
`ifdef MISALIGN_TRAP_EN
         exp_mis = 0;
`endif
      end
   endtask

   task automatic alu_op(input logic [4:0] rd, input logic [6:0] opc, input logic [31:0] val);
      i_valid = 1; i_op_type = 0; i_rd_num = rd; i_opcode = opc; i_alu_out = val; i_func_3 = 3'b000;
      tick();
      i_valid = 0;
      exp_valid = 1; exp_req = 0; exp_stall = 0; exp_err = 0;
      exp_rd = rd; exp_data = val; exp_wen = (rd != 0) && opc != OPC_ST && opc != OPC_BR;
`ifdef MISALIGN_TRAP_EN
      exp_mis = 0;
`endif
   endtask

   // ack_at: WAIT_ACK cycle (1-based) in which mem_ack pulses; 0 = never
   task automatic mem_op(input logic [4:0] rd, input logic [6:0] opc, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] rs2, input logic [31:0] rdat,
                         input int ack_at);
      logic st, done;
      st = (opc == OPC_ST);
      i_valid = 1; i_op_type = 1; i_rd_num = rd; i_opcode = opc; i_func_3 = f3;
      i_alu_out = a; i_rs_2 = rs2;
      tick();
      i_valid = 0;
`ifdef MISALIGN_TRAP_EN
      if (m_misaligned(a, f3)) begin
         exp_valid = 1; exp_mis = 1; exp_wen = 0; exp_err = 0; exp_req = 0; exp_stall = 0;
         exp_rd = rd; exp_data = a;
         return;
      end
      exp_mis = 0;
`endif
      exp_valid = 0; exp_req = 1; exp_stall = 1; exp_we = st;
      exp_addr = a - (a % 4);
      exp_be = st ? m_be(a, f3) : 4'hF;
      exp_wdata = m_wdata(rs2, f3);
      obs_addr = mem_addr; obs_be = mem_be; obs_wdata = mem_wdata;
      done = 0;
      for (int cyc = 1; cyc <= TMO && !done; cyc++) begin
         if (cyc == ack_at) begin
            mem_ack = 1; mem_rdata = rdat;
            tick();
            mem_ack = 0; mem_rdata = 32'hDEAD_BEEF;
            exp_valid = 1; exp_req = 0; exp_stall = 0; exp_err = 0; exp_rd = rd;
            exp_data = st ? a : m_load(rdat, a, f3);
            exp_wen = (rd != 0) && !st;
            done = 1;
         end else if (cyc == TMO) begin
            tick();
            exp_valid = 1; exp_req = 0; exp_stall = 0; exp_err = 1; exp_rd = rd;
            exp_data = 0; exp_wen = 0;
            done = 1;
         end else begin
            tick();
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1; i_valid = 0; i_op_type = 0; i_alu_out = 0; i_rs_2 = 0; i_rd_num = 0;
      i_opcode = 0; i_func_3 = 0; mem_ack = 0; mem_rdata = 32'hDEAD_BEEF;
      tick(); tick();
      chk("rst_wb_en", o_wb_en, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_be", mem_be, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      rst = 0;
      idle(1);

      alu_op(5'd5, OPC_ALU, 32'h0000_0123);
      chk("addi_lit", o_wb_data, 32'h0000_0123);
      idle(2);

      mem_op(5'd6, OPC_LD, 3'b000, 32'h103, 0, 32'h80FF_FF7F, 3);
      chk("lb_lit", o_wb_data, 32'hFFFF_FF80);
      mem_op(5'd7, OPC_LD, 3'b101, 32'h102, 0, 32'hBEEF_1234, 1);
      chk("lhu_lit", o_wb_data, 32'h0000_BEEF);
      mem_op(5'd9, OPC_ST, 3'b000, 32'h201, 32'h0000_00AB, 0, 2);
      chk("sb_addr_lit", obs_addr, 32'h200);
      chk("sb_be_lit", obs_be, 4'b0010);
      chk("sb_lane_lit", (obs_wdata >> 8) & 32'hFF, 32'hAB);
      chk("sb_wen_lit", o_wb_en, 0);
      mem_op(5'd1, OPC_ST, 3'b001, 32'h302, 32'h1234_ABCD, 0, 1);
      mem_op(5'd2, OPC_ST, 3'b010, 32'h400, 32'hCAFE_F00D, 0, 1);
      mem_op(5'd3, OPC_LD, 3'b001, 32'h500, 0, 32'h1234_8001, 2);
      mem_op(5'd4, OPC_LD, 3'b100, 32'h501, 0, 32'h0000_80FF, 1);
      idle(1);
      mem_op(5'd8, OPC_LD, 3'b010, 32'h102, 0, 32'h1122_3344, 1);
`ifndef MISALIGN_TRAP_EN
      chk("lw_force_align_lit", obs_addr, 32'h100);
`endif
      idle(1);
      mem_op(5'd0, OPC_LD, 3'b010, 32'h600, 0, 32'h5555_AAAA, 1);
      alu_op(5'd3, OPC_BR, 32'h0000_0001);
      mem_op(5'd10, OPC_LD, 3'b010, 32'h700, 0, 32'h0BAD_F00D, TMO);
      mem_op(5'd11, OPC_LD, 3'b010, 32'h800, 0, 32'h0, 0);
      chk("tmo_err_lit", o_bus_err, 1);
      idle(2);

      // reset during an outstanding access
      i_valid = 1; i_op_type = 1; i_rd_num = 5'd12; i_opcode = OPC_LD; i_func_3 = 3'b010;
      i_alu_out = 32'h900;
      tick();
      i_valid = 0;
      exp_req = 1; exp_stall = 1; exp_we = 0; exp_addr = 32'h900; exp_be = 4'hF;
      tick(); tick();
      #2 rst = 1;
      exp_req = 0; exp_stall = 0; exp_valid = 0; exp_rd = 0; exp_data = 0;
      #1;
      chk("rst_mid_req_lit", mem_req, 0);
      chk("rst_mid_stall_lit", o_stall, 0);
      chk("rst_mid_data_lit", o_wb_data, 0);
      tick();
      rst = 0;
      idle(1);
      alu_op(5'd13, OPC_ALU, 32'hA5A5_0001);
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
